multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and write-back for the load, op-imm, op (R-type), store, branch and jal opcode classes, and drives the datapath selects: PC, IR, register file, ALU operand mux and memory port. The immediate generator decodes from the same IR contents this block reads. Unsupported encodings park the core in a sticky trap state.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- instr  in  32  IR contents; stable from DECODE until the next FETCH
- mem_ready  in  1  memory handshake; completes the access in the cycle it is high with mem_req
- alu_zero  in  1  ALU result == 0; valid in EXEC
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC update strobe
- pc_src  out  2  00 = PC+4, 01 = branch target (PC+imm), 10 = jal target (PC+imm)
- reg_we  out  1  register file write strobe
- wb_sel  out  2  00 = ALU, 01 = memory data register, 10 = PC+4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct3/funct7 decoded
- illegal  out  1  sticky trap flag
- state  out  3  FSM state, for debug

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Opcode classes: load 0000011, op-imm 0010011, op 0110011, store 0100011, branch 1100011, jal 1101111.
- The opcode class and funct3 are latched on the DECODE cycle.
- All outputs are a combinational function of the registered state, the latched class, mem_ready and alu_zero. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, mem_addr_sel=0. ir_we=mem_ready. Moves to DECODE on mem_ready; otherwise holds.
- DECODE: all strobes 0.
  - Next state is TRAP if the opcode is not in the class list, or if the class is branch and funct3 is not 000 (beq) or 001 (bne).
  - Otherwise next state is EXEC.
- EXEC, alu_src_b and alu_op per class:
  - op: alu_src_b=0, alu_op=10, then WB.
  - op-imm: alu_src_b=1, alu_op=10, then WB.
  - load/store: alu_src_b=1, alu_op=00, then MEM.
  - branch: alu_src_b=0, alu_op=01, pc_we=1. pc_src=01 if taken (beq: alu_zero; bne: !alu_zero), else 00. Then FETCH.
  - jal: pc_we=1, pc_src=10, reg_we=1, wb_sel=10. Then FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store. Holds until mem_ready.
  - Store: on the mem_ready cycle pc_we=1, pc_src=00, then FETCH.
  - Load: on mem_ready, go to WB. The datapath captures read data on that cycle.
- WB: reg_we=1, wb_sel=01 for load or 00 for op/op-imm; pc_we=1, pc_src=00. Then FETCH.
- TRAP: all strobes 0, illegal=1. Holds until reset.

## Timing
- Reset (asynchronous, immediate): state=IDLE, illegal=0, latched class/funct3 cleared, every output 0.
- Reset asserted mid-access drops mem_req in the same cycle, with no clock edge needed. There is no partial write-back.
- First mem_req is asserted in the 2nd cycle after rst_n deasserts (1 cycle in IDLE, then FETCH).
- Zero-wait cycle counts, FETCH to next FETCH: branch 3, jal 3, op/op-imm 4, store 4, load 5.
- Each wait cycle (mem_ready=0 in FETCH or MEM) adds exactly 1 cycle. mem_req stays high and mem_we/mem_addr_sel stay stable while waiting.
- mem_ready outside FETCH/MEM is ignored.
- pc_we is high exactly one cycle per retired instruction.
- reg_we is high at most one cycle per instruction and never for store or branch.
- The PC update and the register write for jal/WB happen on the same edge; the datapath uses the pre-update PC for PC+4.
- instr changes outside DECODE have no effect on the current instruction.

## Test plan
- Reset: hold rst_n=0 in FETCH while mem_req=1 → mem_req drops without a clock edge, state=0. Release → state 0, then 1.
- addi (instr 0x00500093), mem_ready always 1 → states 1,2,3,5,1. In EXEC alu_src_b=1, alu_op=10. In WB reg_we=1, wb_sel=00, pc_we=1, pc_src=00.
- lw (0x0000A103) with 2 wait cycles in MEM → MEM lasts 3 cycles with mem_req=1, mem_addr_sel=1, mem_we=0. Then WB with wb_sel=01. Total 7 cycles.
- beq (0x00000463): alu_zero=1 → EXEC pc_we=1, pc_src=01. Repeat with alu_zero=0 → pc_src=00. Both take 3 cycles and never assert reg_we.
- jal (0x008000EF) → EXEC pc_we=1, pc_src=10, reg_we=1, wb_sel=10, then FETCH. sw (0x00112023) → MEM mem_we=1, no reg_we.
- Illegal opcode 0x0000007F, and branch funct3=010 (0x00002063) → TRAP (state 7), illegal=1, held for 20 cycles with all strobes 0. Only rst_n clears it.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, and drives the datapath selects.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_LOAD   = 3'd1,
    C_OPIMM  = 3'd2,
    C_OP     = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5,
    C_JAL    = 3'd6
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, dec_cls;
  logic [2:0] f3_q;
  logic       dec_legal;
  logic       br_taken;
  logic       unused_bits;

  assign unused_bits = ^{instr[31:15], instr[11:7], f3_q[2:1]};

  always_comb begin
    dec_cls = C_NONE;
    case (instr[6:0])
      7'b0000011: dec_cls = C_LOAD;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0110011: dec_cls = C_OP;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_cls = C_NONE;
    endcase
  end

  // Only beq (000) and bne (001) are implemented in the branch class.
  assign dec_legal = (dec_cls != C_NONE) &&
                     !((dec_cls == C_BRANCH) && (instr[14:13] != 2'b00));

  assign br_taken = f3_q[0] ? !alu_zero : alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        f3_q  <= instr[14:12];
      end
    end
  end

  // Memory handshake: an access completes in the cycle where mem_req and
  // mem_ready are both high; until then mem_req, mem_we and mem_addr_sel hold.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    illegal      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (cls_q)
          C_OP: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_OPIMM: begin
            alu_src_b = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BRANCH: begin
            alu_op  = 2'b01;
            pc_we   = 1'b1;
            pc_src  = br_taken ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            reg_we  = 1'b1;
            wb_sel  = 2'b10;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (cls_q == C_LOAD) ? 2'b01 : 2'b00;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: reset corners, a vector table,
// trap sequences and randomized instructions against a transaction model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src, wb_sel, alu_op;
  logic        alu_src_b, illegal;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    int n_regwe;
    int pc_src;
    int wb_sel;
    int n_req;
    int n_we;
    int n_asel;
    int srcb;
    int aluop;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        z;
    int          cycles;
    int          n_regwe;
    int          pc_src;
    int          wb_sel;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Transaction-level expectations derived from the instruction class.
  function automatic exp_t model(input logic [31:0] ins, input int fw,
                                 input int mw, input logic z);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    bit ld, oi, op, st, br, jl;
    opc = ins[6:0];
    f3  = ins[14:12];
    ld = (opc == 7'h03); oi = (opc == 7'h13); op = (opc == 7'h33);
    st = (opc == 7'h23); br = (opc == 7'h63); jl = (opc == 7'h6f);
    e.cycles  = fw + ((br || jl) ? 3 : (ld ? 5 : 4)) + ((ld || st) ? mw : 0);
    e.n_regwe = (ld || oi || op || jl) ? 1 : 0;
    e.wb_sel  = ld ? 1 : (jl ? 2 : 0);
    if (jl)      e.pc_src = 2;
    else if (br) e.pc_src = ((f3 == 3'd0) ? z : !z) ? 1 : 0;
    else         e.pc_src = 0;
    e.n_req  = fw + 1 + ((ld || st) ? mw + 1 : 0);
    e.n_we   = st ? mw + 1 : 0;
    e.n_asel = (ld || st) ? mw + 1 : 0;
    e.srcb   = (ld || st || oi) ? 1 : 0;
    e.aluop  = (op || oi) ? 2 : (br ? 1 : 0);
    return e;
  endfunction

  // Runs one legal instruction starting from FETCH until FETCH is re-entered.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input int fw, input int mw, input logic z,
                           input exp_t e);
    int cyc = 0, fleft = fw, mleft = mw;
    int n_pcwe = 0, n_regwe = 0, n_irwe = 0, n_req = 0, n_we = 0, n_asel = 0;
    int n_ill = 0, last_pcsrc = -1, last_wbsel = -1, srcb = -1, aluop = -1;
    bit left = 0, done = 0;
    for (int k = 0; k < 60; k++) begin
      if (state == 3'd1 && left) begin
        done = 1;
        break;
      end
      cyc++;
      if (state != 3'd1) left = 1;
      instr    = (state == 3'd1) ? $urandom : ins;
      alu_zero = (state == 3'd3) ? z : 1'($urandom_range(0, 1));
      case (state)
        3'd1: begin
          mem_ready = (fleft == 0);
          if (fleft > 0) fleft--;
        end
        3'd4: begin
          mem_ready = (mleft == 0);
          if (mleft > 0) mleft--;
        end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (pc_we)  begin n_pcwe++;  last_pcsrc = int'(pc_src); end
      if (reg_we) begin n_regwe++; last_wbsel = int'(wb_sel); end
      if (ir_we)  n_irwe++;
      if (mem_req) begin
        n_req++;
        if (mem_we) n_we++;
        if (mem_addr_sel) n_asel++;
      end
      if (illegal) n_ill++;
      if (state == 3'd3) begin
        srcb  = int'(alu_src_b);
        aluop = int'(alu_op);
      end
      @(negedge clk);
    end
    check({tag, " done"}, int'(done), 1);
    check({tag, " cycles"}, cyc, e.cycles);
    check({tag, " pc_we_count"}, n_pcwe, 1);
    check({tag, " reg_we_count"}, n_regwe, e.n_regwe);
    check({tag, " ir_we_count"}, n_irwe, 1);
    check({tag, " pc_src"}, last_pcsrc, e.pc_src);
    if (e.n_regwe > 0) check({tag, " wb_sel"}, last_wbsel, e.wb_sel);
    check({tag, " mem_req_cycles"}, n_req, e.n_req);
    check({tag, " mem_we_cycles"}, n_we, e.n_we);
    check({tag, " addr_sel_cycles"}, n_asel, e.n_asel);
    check({tag, " alu_src_b"}, srcb, e.srcb);
    check({tag, " alu_op"}, aluop, e.aluop);
    check({tag, " illegal"}, n_ill, 0);
  endtask

  task automatic wait_fetch(input string tag);
    bit ok = 0;
    for (int k = 0; k < 4; k++) begin
      if (state == 3'd1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check({tag, " reach_fetch"}, int'(ok), 1);
  endtask

  task automatic run_trap(input string tag, input logic [31:0] ins);
    bit hit = 0;
    int bad_state = 0, bad_ill = 0, bad_strobe = 0;
    for (int k = 0; k < 10; k++) begin
      if (state == 3'd7) begin
        hit = 1;
        break;
      end
      instr     = (state == 3'd1) ? 32'h0000_0013 : ins;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
    end
    check({tag, " trap_entered"}, int'(hit), 1);
    for (int k = 0; k < 20; k++) begin
      instr     = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      #1;
      if (state != 3'd7) bad_state++;
      if (!illegal) bad_ill++;
      if (mem_req || mem_we || ir_we || pc_we || reg_we) bad_strobe++;
      @(negedge clk);
    end
    check({tag, " trap_state_held"}, bad_state, 0);
    check({tag, " illegal_held"}, bad_ill, 0);
    check({tag, " trap_strobes"}, bad_strobe, 0);
    rst_n = 1'b0;
    #1;
    check({tag, " reset_clears_illegal"}, int'(illegal), 0);
    check({tag, " reset_state"}, int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_fetch(tag);
  endtask

  vec_t vecs[$];

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    instr     = 32'h0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;

    vecs.push_back('{32'h00500093, 0, 0, 1'b0, 4, 1, 0, 0}); // addi
    vecs.push_back('{32'h0000A103, 0, 2, 1'b0, 7, 1, 0, 1}); // lw, 2 waits
    vecs.push_back('{32'h00000463, 0, 0, 1'b1, 3, 0, 1, 0}); // beq taken
    vecs.push_back('{32'h00000463, 0, 0, 1'b0, 3, 0, 0, 0}); // beq not taken
    vecs.push_back('{32'h008000EF, 0, 0, 1'b0, 3, 1, 2, 2}); // jal
    vecs.push_back('{32'h00112023, 0, 0, 1'b0, 4, 0, 0, 0}); // sw
    vecs.push_back('{32'h002081B3, 1, 0, 1'b0, 5, 1, 0, 0}); // add, fetch wait
    vecs.push_back('{32'h00209463, 0, 0, 1'b0, 3, 0, 1, 0}); // bne taken
    vecs.push_back('{32'h00112023, 2, 1, 1'b0, 7, 0, 0, 0}); // sw, waits

    // Reset and asynchronous reset during a pending fetch.
    repeat (3) @(negedge clk);
    #1;
    check("reset mem_req", int'(mem_req), 0);
    check("reset state", int'(state), 0);
    check("reset illegal", int'(illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release state_idle", int'(state), 0);
    check("release mem_req_idle", int'(mem_req), 0);
    @(negedge clk);
    #1;
    check("release state_fetch", int'(state), 1);
    check("release mem_req_fetch", int'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("async mem_req_drop", int'(mem_req), 0);
    check("async state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerelease state_idle", int'(state), 0);
    @(negedge clk);
    #1;
    check("rerelease state_fetch", int'(state), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      e = model(vecs[i].ins, vecs[i].fw, vecs[i].mw, vecs[i].z);
      e.cycles  = vecs[i].cycles;
      e.n_regwe = vecs[i].n_regwe;
      e.pc_src  = vecs[i].pc_src;
      e.wb_sel  = vecs[i].wb_sel;
      run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].fw,
                vecs[i].mw, vecs[i].z, e);
    end

    run_trap("trap_opcode", 32'h0000007F);
    run_trap("trap_funct3", 32'h00002063);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      logic [6:0]  opcs [6];
      int fw, mw, k;
      logic z;
      opcs = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h6f};
      k   = $urandom_range(0, 5);
      ins = $urandom;
      ins[6:0] = opcs[k];
      if (k == 4) ins[14:12] = 3'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      z  = 1'($urandom_range(0, 1));
      run_instr($sformatf("rnd%0d", i), ins, fw, mw, z, model(ins, fw, mw, z));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
